spi_slave_regfile: RTL and testbench

Chip-side SPI responder: receives the SPI master's serial traffic (sck/mosi/cs) from the FPGA test controller and answers on miso. Decodes a command byte, then writes into or reads from a local byte-wide register file. Used as a synthesizable chip model for loopback bring-up of the FPGA SPI path, and as the SPI target block in the test chip. Runs entirely in the system clock domain; sck is oversampled.

---
 rtl/spi_slave_regfile_if.sv | 24 ++
 rtl/spi_slave_regfile.sv | 196 +++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between the FPGA test controller (master) and the chip-side responder (slave).
interface spi_slave_regfile_if;
    logic spi_sck;
    logic spi_cs;
    logic spi_mosi;
    logic spi_miso;
    logic miso_oe;

    modport master (
        output spi_sck,
        output spi_cs,
        output spi_mosi,
        input  spi_miso,
        input  miso_oe
    );

    modport slave (
        input  spi_sck,
        input  spi_cs,
        input  spi_mosi,
        output spi_miso,
        output miso_oe
    );
endinterface

// File: rtl/spi_slave_regfile.sv
// Mode-0 SPI responder with an oversampled front end and a byte-wide register file.
// Frame: command byte {rw, addr[6:0]} followed by auto-incrementing data bytes.
module spi_slave_regfile #(
    parameter int unsigned NREG = 16
) (
    input  logic               CLK,
    input  logic               rst_n,
    spi_slave_regfile_if.slave spi,
    output logic [NREG*8-1:0]  regs_flat,
    output logic               wr_pulse,
    output logic [6:0]         wr_addr,
    output logic [7:0]         wr_data,
    output logic               frame_done,
    output logic               abort_pulse
);
    localparam int unsigned AW    = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [7:0]  NRegB = 8'(NREG);

    typedef enum logic [1:0] {StIdle, StCmd, StWdata, StRdata} state_e;

    logic       sck_s1_q, sck_s2_q, sck_s3_q;
    logic       cs_s1_q, cs_s2_q, cs_s3_q;
    logic       mosi_s1_q, mosi_s2_q;
    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic [6:0] addr_q, addr_d;
    logic       any_byte_q, any_byte_d;
    logic       miso_q, miso_d;
    logic       miso_oe_q, miso_oe_d;
    logic [7:0] regs_q [NREG];
    logic [7:0] regs_d [NREG];
    logic       wr_pulse_q, wr_pulse_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       frame_done_q, frame_done_d;
    logic       abort_q, abort_d;

    logic       sck_rise, sck_fall, cs_rise, cs_fall;
    logic [7:0] byte_in;
    logic [6:0] rd_addr;
    logic [7:0] rd_val;

    assign sck_rise = sck_s2_q & ~sck_s3_q;
    assign sck_fall = ~sck_s2_q & sck_s3_q;
    assign cs_rise  = cs_s2_q & ~cs_s3_q;
    assign cs_fall  = ~cs_s2_q & cs_s3_q;
    assign byte_in  = {shift_q[6:0], mosi_s2_q};

    // Next read byte: addressed by the command itself, or the following address in a burst.
    always_comb begin
        rd_addr = (state_q == StCmd) ? byte_in[6:0] : addr_q + 7'd1;
        rd_val  = 8'h00;
        if ({1'b0, rd_addr} < NRegB) begin
            rd_val = regs_q[rd_addr[AW-1:0]];
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        addr_d       = addr_q;
        any_byte_d   = any_byte_q;
        miso_d       = miso_q;
        miso_oe_d    = miso_oe_q;
        regs_d       = regs_q;
        wr_pulse_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        abort_d      = 1'b0;

        if (cs_rise) begin
            state_d   = StIdle;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            if (state_q != StIdle) begin
                if (bit_cnt_q != 3'd0) begin
                    abort_d = 1'b1;
                end else if (any_byte_q) begin
                    frame_done_d = 1'b1;
                end
            end
        end else if (state_q == StIdle) begin
            if (cs_fall) begin
                state_d    = StCmd;
                bit_cnt_d  = 3'd0;
                shift_d    = 8'h00;
                tx_d       = 8'h00;
                any_byte_d = 1'b0;
            end
        end else if (!cs_s2_q && sck_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                any_byte_d = 1'b1;
                unique case (state_q)
                    StCmd: begin
                        addr_d = byte_in[6:0];
                        if (byte_in[7]) begin
                            state_d = StRdata;
                            tx_d    = rd_val;
                        end else begin
                            state_d = StWdata;
                        end
                    end
                    StWdata: begin
                        if ({1'b0, addr_q} < NRegB) begin
                            regs_d[addr_q[AW-1:0]] = byte_in;
                            wr_pulse_d             = 1'b1;
                            wr_addr_d              = addr_q;
                            wr_data_d              = byte_in;
                        end
                        addr_d = addr_q + 7'd1;
                    end
                    StRdata: begin
                        addr_d = addr_q + 7'd1;
                        tx_d   = rd_val;
                    end
                    default: ;
                endcase
            end
        end else if (!cs_s2_q && sck_fall && state_q == StRdata) begin
            miso_d    = tx_q[7];
            tx_d      = {tx_q[6:0], 1'b0};
            miso_oe_d = 1'b1;
        end
    end

    // cs synchronizer resets to "selected" so a cs held low across reset never looks like a
    // fresh falling edge; a frame only starts after the master toggles cs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sck_s1_q     <= 1'b0;
            sck_s2_q     <= 1'b0;
            sck_s3_q     <= 1'b0;
            cs_s1_q      <= 1'b0;
            cs_s2_q      <= 1'b0;
            cs_s3_q      <= 1'b0;
            mosi_s1_q    <= 1'b0;
            mosi_s2_q    <= 1'b0;
            state_q      <= StIdle;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            tx_q         <= 8'h00;
            addr_q       <= 7'd0;
            any_byte_q   <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            regs_q       <= '{default: 8'h00};
            wr_pulse_q   <= 1'b0;
            wr_addr_q    <= 7'd0;
            wr_data_q    <= 8'h00;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            sck_s1_q     <= spi.spi_sck;
            sck_s2_q     <= sck_s1_q;
            sck_s3_q     <= sck_s2_q;
            cs_s1_q      <= spi.spi_cs;
            cs_s2_q      <= cs_s1_q;
            cs_s3_q      <= cs_s2_q;
            mosi_s1_q    <= spi.spi_mosi;
            mosi_s2_q    <= mosi_s1_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            any_byte_q   <= any_byte_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            regs_q       <= regs_d;
            wr_pulse_q   <= wr_pulse_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            abort_q      <= abort_d;
        end
    end

    for (genvar i = 0; i < int'(NREG); i++) begin : g_flat
        assign regs_flat[8*i +: 8] = regs_q[i];
    end

    assign spi.spi_miso = miso_q;
    assign spi.miso_oe  = miso_oe_q;
    assign wr_pulse     = wr_pulse_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign frame_done   = frame_done_q;
    assign abort_pulse  = abort_q;
endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed SPI master stimulus with queue-based scoreboard for spi_slave_regfile (NREG=16).
module tb_spi_slave_regfile;
    localparam logic [1:0] EvFrame = 2'd1;
    localparam logic [1:0] EvAbort = 2'd2;

    logic         clk;
    logic         rst_n;
    logic [127:0] regs_flat;
    logic         wr_pulse;
    logic [6:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         frame_done;
    logic         abort_pulse;

    spi_slave_regfile_if sif ();

    spi_slave_regfile #(.NREG(16)) dut (
        .CLK        (clk),
        .rst_n      (rst_n),
        .spi        (sif),
        .regs_flat  (regs_flat),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .abort_pulse(abort_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [14:0] exp_wr [$];
    logic [1:0]  exp_evt [$];
    logic [7:0]  exp_rd [$];
    logic [7:0]  tx_bytes [$];
    logic [7:0]  model [16];
    logic [7:0]  rx_obs;
    logic [14:0] wr_e;
    logic [1:0]  ev_e;
    event        rx_ev;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[8*i +: 8] = model[i];
        return f;
    endfunction

    task automatic exp_write(input logic [6:0] a, input logic [7:0] d);
        if (a < 7'd16) begin
            exp_wr.push_back({a, d});
            model[a[3:0]] = d;
        end
    endtask

    task automatic check_reset(input string name);
        chk({name, " miso"}, sif.spi_miso, 0);
        chk({name, " miso_oe"}, sif.miso_oe, 0);
        chk({name, " regs_flat"}, regs_flat, 0);
        chk({name, " wr_pulse"}, wr_pulse, 0);
        chk({name, " wr_addr"}, wr_addr, 0);
        chk({name, " wr_data"}, wr_data, 0);
        chk({name, " frame_done"}, frame_done, 0);
        chk({name, " abort_pulse"}, abort_pulse, 0);
    endtask

    // One byte (or nbits of it), MSB first; miso is sampled just before each rising edge.
    task automatic xfer(input logic [7:0] tx, input int nbits, input int half, input bit rdbyte,
                        output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sif.spi_mosi = tx[7-i];
            repeat (half) @(negedge clk);
            rx[7-i] = sif.spi_miso;
            chk("miso_oe during bit", sif.miso_oe, rdbyte);
            if (!rdbyte) chk("miso low while not driving", sif.spi_miso, 0);
            sif.spi_sck = 1'b1;
            repeat (half) @(negedge clk);
            sif.spi_sck = 1'b0;
        end
    endtask

    task automatic frame(input int last_bits, input int half);
        logic [7:0] rx;
        int         nb;
        bit         rd;
        rd = tx_bytes[0][7];
        sif.spi_cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < tx_bytes.size(); b++) begin
            nb = (b == tx_bytes.size() - 1) ? last_bits : 8;
            xfer(tx_bytes[b], nb, half, rd && (b > 0), rx);
            if (rd && b > 0 && nb == 8) begin
                rx_obs = rx;
                -> rx_ev;
            end
        end
        repeat (half) @(negedge clk);
        sif.spi_cs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_wr.size() + exp_evt.size() + exp_rd.size()) != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({name, " pending expectations"}, exp_wr.size() + exp_evt.size() + exp_rd.size(), 0);
    endtask

    always @(negedge clk) begin
        if (wr_pulse) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected wr_pulse: addr 0x%0h data 0x%0h, none expected",
                         wr_addr, wr_data);
            end else begin
                wr_e = exp_wr.pop_front();
                chk("wr_addr", wr_addr, wr_e[14:8]);
                chk("wr_data", wr_data, wr_e[7:0]);
                chk("regs_flat at write", regs_flat[8*int'(wr_e[11:8]) +: 8], wr_e[7:0]);
            end
        end
        if (frame_done || abort_pulse) begin
            if (exp_evt.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected frame event: frame_done %0b abort_pulse %0b, none expected",
                         frame_done, abort_pulse);
            end else begin
                ev_e = exp_evt.pop_front();
                chk("frame event kind", {frame_done, abort_pulse},
                    {ev_e == EvFrame, ev_e == EvAbort});
            end
        end
    end

    initial begin
        forever begin
            @(rx_ev);
            if (exp_rd.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected read byte: got 0x%0h, none expected", rx_obs);
            end else begin
                chk("read byte on miso", rx_obs, exp_rd.pop_front());
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        sif.spi_sck  = 1'b0;
        sif.spi_cs   = 1'b1;
        sif.spi_mosi = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        tx_bytes = '{8'h03, 8'hA5};
        exp_write(7'd3, 8'hA5);
        exp_evt.push_back(EvFrame);
        frame(8, 4);
        drain("write 0x03");
        chk("reg3 after write", regs_flat[31:24], 8'hA5);

        tx_bytes = '{8'h0E, 8'h11, 8'h22, 8'h33};
        exp_write(7'd14, 8'h11);
        exp_write(7'd15, 8'h22);
        exp_write(7'd16, 8'h33);
        exp_evt.push_back(EvFrame);
        frame(8, 4);
        drain("burst write 0x0E");
        chk("reg14", regs_flat[119:112], 8'h11);
        chk("reg15", regs_flat[127:120], 8'h22);

        tx_bytes = '{8'h83, 8'h00};
        exp_rd.push_back(8'hA5);
        exp_evt.push_back(EvFrame);
        frame(8, 8);
        drain("read 0x83");
        chk("regs unchanged by read", regs_flat, model_flat());

        tx_bytes = '{8'h00, 8'h3C};
        exp_write(7'd0, 8'h3C);
        exp_evt.push_back(EvFrame);
        frame(8, 4);
        drain("write reg0");

        tx_bytes = '{8'hFF, 8'h00, 8'h00};
        exp_rd.push_back(8'h00);
        exp_rd.push_back(8'h3C);
        exp_evt.push_back(EvFrame);
        frame(8, 8);
        drain("read 0xFF wrap");

        tx_bytes = '{8'h02, 8'hFF};
        exp_evt.push_back(EvAbort);
        frame(5, 4);
        drain("abort mid-byte");
        chk("reg2 after abort", regs_flat[23:16], 8'h00);

        begin
            logic [7:0] dummy;
            sif.spi_cs = 1'b0;
            repeat (8) @(negedge clk);
            xfer(8'h7F, 4, 4, 1'b0, dummy);
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            check_reset("reset mid-frame");
            for (int i = 0; i < 16; i++) model[i] = 8'h00;
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            sif.spi_cs = 1'b1;
            repeat (12) @(negedge clk);
        end

        tx_bytes = '{8'h01, 8'h5A};
        exp_write(7'd1, 8'h5A);
        exp_evt.push_back(EvFrame);
        frame(8, 4);
        drain("write after reset");
        chk("regs after reset and write", regs_flat, 128'h5A00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
